mem_resp_encoder: RTL and testbench
===================================

# mem_resp_encoder

Return-path companion to the 2-to-4 bank decoder in the dual-port RAM SoC. The decoder fans a 2-bit bank index out to four one-hot bank selects; this block takes the four per-bank one-hot read-response strobes, encodes them back to a 2-bit bank index, and captures the selected bank's read data. It queues results in a small FIFO and presents them to the port controller over a valid/ready handshake. It also flags protocol violations: multi-hot strobes and overflow.

## Interface
Parameters:
- DATA_W, 8, width of one bank's read data
- DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- bank_hit  input  4  one-hot response strobes; bit i = bank i returns data this cycle
- bank_rdata  input  4*DATA_W  concatenated bank data; bank i occupies bits [i*DATA_W +: DATA_W]
- out_ready  input  1  consumer accepts the head entry
- err_clr  input  1  clears sticky error flags
- out_valid  output  1  head entry valid
- out_bank  output  2  encoded bank index of head entry
- out_data  output  DATA_W  data of head entry
- out_count  output  $clog2(DEPTH)+1  current occupancy
- err_multi  output  1  sticky; a multi-hot bank_hit was seen
- err_ovf  output  1  sticky; a push was dropped because the FIFO was full

Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- Encode: bank_hit 0001→0, 0010→1, 0100→2, 1000→3. Data is muxed from the matching bank_rdata slice.
- bank_hit == 0000: no push; normal idle.
- Multi-hot bank_hit (two or more bits set): err_multi sets. Push behaviour depends on the configuration macro (see Configuration).
- Push condition: valid one-hot encode AND (count < DEPTH OR pop this cycle).
- Pop condition: out_valid AND out_ready.
- Push when full with no pop: entry dropped, err_ovf sets, FIFO contents unchanged.
- Full with simultaneous pop and push: both occur; count stays DEPTH; FIFO order is preserved.
- Empty with simultaneous push, and out_ready high: no bypass; the entry is written and pops at the earliest one cycle later.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is tracked separately, range 0..DEPTH.
- Sticky flags stay set until err_clr or rst. If err_clr and a new error occur in the same cycle, the error wins and the flag remains 1.
- Outputs out_bank and out_data are read from FIFO storage at the read pointer and are stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: out_valid=0, out_bank=0, out_data=0, out_count=0, err_multi=0, err_ovf=0. Pointers are 0. Storage contents are don't-care but never visible, because out_valid=0.
- Latency: a strobe sampled at edge N gives out_valid=1 after edge N, i.e. visible in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- out_count updates on the same edge as the push/pop it reflects.
- Error flags assert on the edge that samples the offending strobe.
- rst asserted mid-operation: on that edge all entries are discarded, all outputs return to their reset values, and any strobe in the same cycle is ignored.
- The handshake is AXI-style. out_valid never deasserts without a pop. Head data never changes while stalled.

## Configuration
- MEM_RESP_PRIORITY_EN defined: a multi-hot bank_hit is encoded with highest-index priority (e.g. 0110→2, using bank 2 data). It is pushed like a valid strobe, subject to the normal full/overflow rules, and still sets err_multi.
- Not defined: a multi-hot bank_hit is dropped (no push) and sets err_multi.

## Test plan
- Reset, then strobe each bank once (0001, 0010, 0100, 1000) with data 0x11/0x22/0x33/0x44 and out_ready=1 → outputs (0,0x11), (1,0x22), (2,0x33), (3,0x44) in order, each one cycle after its strobe; out_count returns to 0.
- Hold out_ready=0 and push 5 strobes (bank 2, DEPTH=4) → out_count=4, err_ovf=1, the 5th entry is absent, and the head remains the first entry.
- While full, raise out_ready and strobe bank 1 with 0xA5 in the same cycle → out_count stays 4; 0xA5 appears as the last of the 4 entries drained.
- Strobe 0110: without the macro → no push, out_count=0, err_multi=1. With MEM_RESP_PRIORITY_EN → entry (2, bank 2 data) and err_multi=1. Then pulse err_clr → err_multi=0.
- Fill 3 entries, assert rst for one cycle while strobing bank 3 → next cycle out_valid=0, out_count=0, both error flags 0, no entry for bank 3.
- Random one-hot strobes with random out_ready over 1000 cycles → output sequence matches a reference queue model; check pointer wrap-around and that head data is never changed while out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/mem_resp_encoder.sv
// mem_resp_encoder: encodes one-hot bank read strobes to a bank index, queues {bank,data} in a FIFO with sticky error flags.
// Define MEM_RESP_PRIORITY_EN to push multi-hot strobes with highest-index priority instead of dropping them.
module mem_resp_encoder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              bank_hit,
  input  logic [4*DATA_W-1:0]     bank_rdata,
  input  logic                    out_ready,
  input  logic                    err_clr,
  output logic                    out_valid,
  output logic [1:0]              out_bank,
  output logic [DATA_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]  out_count,
  output logic                    err_multi,
  output logic                    err_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [DATA_W+1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic err_multi_q, err_multi_d, err_ovf_q, err_ovf_d;
  logic multi, enc_valid, push, pop;
  logic [1:0] idx;
  logic [DATA_W-1:0] sel;
  always_comb begin
    multi = (bank_hit & (bank_hit - 4'd1)) != 4'd0;
`ifdef MEM_RESP_PRIORITY_EN
    enc_valid = bank_hit != 4'd0;
`else
    enc_valid = bank_hit != 4'd0 && !multi;
`endif
    idx = bank_hit[3] ? 2'd3 : bank_hit[2] ? 2'd2 : bank_hit[1] ? 2'd1 : 2'd0;
    sel = '0;
    for (int i = 0; i < 4; i++)
      if (idx == 2'(i)) sel = bank_rdata[i*DATA_W +: DATA_W];
    pop = count_q != '0 && out_ready;
    push = enc_valid && (count_q != FULL || pop);
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
    // a new error outranks a clear in the same cycle
    err_multi_d = multi || (err_multi_q && !err_clr);
    err_ovf_d = (enc_valid && !push) || (err_ovf_q && !err_clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      err_multi_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      err_multi_q <= err_multi_d;
      err_ovf_q <= err_ovf_d;
    end
  end
  always_ff @(posedge clk)
    if (push && !rst) mem_q[wr_q] <= {idx, sel};
  assign out_valid = count_q != '0;
  assign out_bank = out_valid ? mem_q[rd_q][DATA_W+1:DATA_W] : 2'd0;
  assign out_data = out_valid ? mem_q[rd_q][DATA_W-1:0] : '0;
  assign out_count = count_q;
  assign err_multi = err_multi_q;
  assign err_ovf = err_ovf_q;
endmodule

// File: tb/tb_mem_resp_encoder.sv
// tb_mem_resp_encoder: directed checks plus a randomized queue-model run for mem_resp_encoder (DATA_W=8, DEPTH=4).
module tb_mem_resp_encoder;
  logic clk = 1'b0;
  logic rst, out_ready, err_clr, out_valid, err_multi, err_ovf;
  logic [3:0] bank_hit;
  logic [31:0] bank_rdata;
  logic [1:0] out_bank;
  logic [7:0] out_data;
  logic [2:0] out_count;
  int checks = 0;
  int failures = 0;
  logic [9:0] q[$];

  mem_resp_encoder #(.DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bank_hit(bank_hit), .bank_rdata(bank_rdata),
    .out_ready(out_ready), .err_clr(err_clr), .out_valid(out_valid),
    .out_bank(out_bank), .out_data(out_data), .out_count(out_count),
    .err_multi(err_multi), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [2:0] cnt, input logic [1:0] b, input logic [7:0] d);
    chk({tag, "_count"}, 32'(out_count), 32'(cnt));
    chk({tag, "_valid"}, 32'(out_valid), 32'(cnt != 3'd0));
    chk({tag, "_bank"}, 32'(out_bank), 32'(b));
    chk({tag, "_data"}, 32'(out_data), 32'(d));
  endtask

  initial begin
    rst = 1'b1; bank_hit = 4'd0; bank_rdata = 32'd0; out_ready = 1'b0; err_clr = 1'b0;
    tick;
    rst = 1'b0;
    chk_head("reset", 3'd0, 2'd0, 8'd0);
    chk("reset_err_multi", 32'(err_multi), 32'd0);
    chk("reset_err_ovf", 32'(err_ovf), 32'd0);

    // one strobe per bank, consumer always ready
    out_ready = 1'b1;
    bank_rdata = 32'h44332211;
    for (int k = 0; k < 4; k++) begin
      bank_hit = 4'(1 << k);
      tick;
      chk_head($sformatf("bank%0d", k), 3'd1, 2'(k), 8'(8'h11 * (k + 1)));
    end
    bank_hit = 4'd0;
    tick;
    chk_head("drain_empty", 3'd0, 2'd0, 8'd0);

    // overflow: five pushes to a stalled FIFO
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bank_hit = 4'b0100;
      bank_rdata = {8'h00, 8'(8'h50 + k), 16'h0000};
      tick;
      if (k == 3) chk("ovf_before", 32'(err_ovf), 32'd0);
    end
    bank_hit = 4'd0;
    chk_head("full", 3'd4, 2'd2, 8'h50);
    chk("ovf_set", 32'(err_ovf), 32'd1);
    tick;
    chk_head("stall_hold", 3'd4, 2'd2, 8'h50);

    // full with simultaneous push and pop
    out_ready = 1'b1;
    bank_hit = 4'b0010;
    bank_rdata = 32'h0000A500;
    tick;
    bank_hit = 4'd0;
    chk_head("full_pushpop", 3'd4, 2'd2, 8'h51);
    tick;
    chk_head("drain1", 3'd3, 2'd2, 8'h52);
    tick;
    chk_head("drain2", 3'd2, 2'd2, 8'h53);
    tick;
    chk_head("drain3", 3'd1, 2'd1, 8'hA5);
    tick;
    chk_head("drain4", 3'd0, 2'd0, 8'd0);
    chk("ovf_sticky", 32'(err_ovf), 32'd1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("ovf_clr", 32'(err_ovf), 32'd0);

    // multi-hot strobe
    out_ready = 1'b0;
    bank_hit = 4'b0110;
    bank_rdata = 32'h00772200;
    tick;
    bank_hit = 4'd0;
    chk("multi_set", 32'(err_multi), 32'd1);
`ifdef MEM_RESP_PRIORITY_EN
    chk_head("multi_prio", 3'd1, 2'd2, 8'h77);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk_head("multi_prio_drain", 3'd0, 2'd0, 8'd0);
`else
    chk_head("multi_drop", 3'd0, 2'd0, 8'd0);
`endif
    err_clr = 1'b1;
    tick;
    chk("multi_clr", 32'(err_multi), 32'd0);
    bank_hit = 4'b0011;
    tick;
    bank_hit = 4'd0;
    chk("clr_vs_err", 32'(err_multi), 32'd1);
    err_clr = 1'b0;
`ifdef MEM_RESP_PRIORITY_EN
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
`endif

    // reset mid-operation with a concurrent strobe; err_multi is still set here
    for (int k = 0; k < 3; k++) begin
      bank_hit = 4'b0001;
      bank_rdata = 32'(8'h60 + k);
      tick;
    end
    chk_head("pre_rst", 3'd3, 2'd0, 8'h60);
    rst = 1'b1;
    bank_hit = 4'b1000;
    bank_rdata = 32'hEE000000;
    tick;
    rst = 1'b0;
    bank_hit = 4'd0;
    chk_head("mid_rst", 3'd0, 2'd0, 8'd0);
    chk("mid_rst_multi", 32'(err_multi), 32'd0);
    chk("mid_rst_ovf", 32'(err_ovf), 32'd0);
    tick;
    chk_head("post_rst", 3'd0, 2'd0, 8'd0);

    // random one-hot traffic against a reference queue
    for (int n = 0; n < 1000; n++) begin
      logic pop, push;
      logic [1:0] b;
      b = 2'($urandom_range(0, 3));
      bank_hit = ($urandom_range(0, 9) < 7) ? 4'(1 << b) : 4'd0;
      bank_rdata = $urandom;
      out_ready = $urandom_range(0, 1) == 1;
      pop = q.size() > 0 && out_ready;
      push = bank_hit != 4'd0 && (q.size() < 4 || pop);
      tick;
      if (pop) void'(q.pop_front());
      if (push) q.push_back({b, bank_rdata[8*b +: 8]});
      if (q.size() > 0)
        chk_head("rand", 3'(q.size()), q[0][9:8], q[0][7:0]);
      else
        chk_head("rand", 3'd0, 2'd0, 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
